// File: rtl/scroll_frame_source.sv
// Scrolling message source: column RAM plus a windowing FSM that presents
// eight consecutive columns (mod the message length) as one atomic 64-bit frame.
module scroll_frame_source #(
   parameter int MSG_COLS  = 32,
   parameter int COL_AW    = 5,
   parameter int DIV_WIDTH = 24
) (
   input  logic                 sys_clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 wr_en,
   input  logic [COL_AW-1:0]    wr_addr,
   input  logic [7:0]           wr_data,
   input  logic [COL_AW:0]      msg_len,
   input  logic [DIV_WIDTH-1:0] step_div,
   output logic [63:0]          frame_out,
   output logic                 frame_valid,
   output logic                 wrapped
);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_COMMIT, S_WAIT} state_t;

   localparam logic [COL_AW:0] C_MSG_COLS = (COL_AW+1)'(MSG_COLS);
   localparam logic [COL_AW:0] C_ONE      = (COL_AW+1)'(1);

   state_t               r_state, w_next_state, w_fetch_target;
   logic [COL_AW:0]      r_len, r_offset, r_addr;
   logic [COL_AW:0]      w_len_clamp, w_offset_start, w_addr_inc, w_offset_inc;
   logic [2:0]           r_k;
   logic [DIV_WIDTH-1:0] r_prescale;
   logic [63:0]          r_staging, w_frame_next;
   logic [7:0]           r_mem [MSG_COLS];
   logic [7:0]           r_rd_data;
   logic                 w_start, w_read, w_shift, w_load, w_commit;

   assign w_len_clamp    = (msg_len > C_MSG_COLS) ? C_MSG_COLS : msg_len;
   assign w_offset_start = (r_offset >= w_len_clamp) ? '0 : r_offset;
   assign w_addr_inc     = (r_addr + C_ONE == r_len) ? '0 : r_addr + C_ONE;
   assign w_offset_inc   = (r_len == '0 || r_offset + C_ONE == r_len) ? '0 : r_offset + C_ONE;
   // An empty message skips the reads and goes straight to the frame load.
   assign w_fetch_target = (w_len_clamp == '0) ? S_DRAIN : S_FETCH;

   // NOTE: registers use <= so every flop samples the values from before the edge.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // NOTE: default assignment first so no path leaves a signal unassigned (no latch).
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (enable) w_next_state = w_fetch_target;
         S_FETCH:  if (r_k == 3'd7) w_next_state = S_DRAIN;
         S_DRAIN:  w_next_state = S_COMMIT;
         S_COMMIT: w_next_state = S_WAIT;
         S_WAIT: begin
            if (!enable)                 w_next_state = S_IDLE;
            else if (r_prescale == '0)   w_next_state = w_fetch_target;
         end
         default:  w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_start  = 1'b0;
      w_read   = 1'b0;
      w_shift  = 1'b0;
      w_load   = 1'b0;
      w_commit = 1'b0;
      case (r_state)
         S_IDLE:   w_start = enable;
         S_FETCH: begin
            w_read  = 1'b1;
            w_shift = (r_k != 3'd0);
         end
         S_DRAIN:  w_load   = 1'b1;
         S_COMMIT: w_commit = 1'b1;
         S_WAIT:   w_start  = enable && (r_prescale == '0);
         default:  ;
      endcase
   end

   // Each row byte shifts right; the column read first ends up in bit 0.
   always_comb begin
      w_frame_next = '0;
      for (int r = 0; r < 8; r++)
         w_frame_next[8*r +: 8] = {r_rd_data[r], r_staging[8*r+1 +: 7]};
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_len       <= '0;
         r_offset    <= '0;
         r_addr      <= '0;
         r_k         <= '0;
         r_prescale  <= '0;
         r_staging   <= '0;
         frame_out   <= '0;
         frame_valid <= 1'b0;
         wrapped     <= 1'b0;
      end else begin
         frame_valid <= w_load;
         wrapped     <= w_load && (r_len != '0) && (r_offset == r_len - C_ONE);
         if (w_start) begin
            r_len    <= w_len_clamp;
            r_offset <= w_offset_start;
            r_addr   <= w_offset_start;
            r_k      <= '0;
         end
         if (w_read) begin
            r_addr <= w_addr_inc;
            r_k    <= r_k + 3'd1;
         end
         if (w_shift) r_staging <= w_frame_next;
         if (w_load)  frame_out <= (r_len == '0) ? '0 : w_frame_next;
         if (w_commit) begin
            r_offset   <= w_offset_inc;
            r_prescale <= step_div;
         end else if (r_state == S_WAIT && r_prescale != '0) begin
            r_prescale <= r_prescale - DIV_WIDTH'(1);
         end
      end
   end

   // NOTE: the column RAM and its read register carry no reset so they map to block RAM;
   // a same-address write and read in one cycle returns the old byte.
   always_ff @(posedge sys_clk) begin
      if (wr_en)  r_mem[wr_addr] <= wr_data;
      if (w_read) r_rd_data <= r_mem[r_addr[COL_AW-1:0]];
   end

endmodule

// File: tb/tb_scroll_frame_source.sv
// Self-checking bench: a cycle-level reference model of the scrolling window is
// compared every cycle, plus hand-computed frames for the key scenarios.
module tb_scroll_frame_source;

   localparam int MSG_COLS  = 32;
   localparam int COL_AW    = 5;
   localparam int DIV_WIDTH = 24;

   logic                 sys_clk  = 1'b0;
   logic                 rst      = 1'b1;
   logic                 enable   = 1'b0;
   logic                 wr_en    = 1'b0;
   logic [COL_AW-1:0]    wr_addr  = '0;
   logic [7:0]           wr_data  = '0;
   logic [COL_AW:0]      msg_len  = '0;
   logic [DIV_WIDTH-1:0] step_div = '0;
   logic [63:0]          frame_out;
   logic                 frame_valid;
   logic                 wrapped;

   int n_checks = 0;
   int n_errors = 0;

   scroll_frame_source #(
      .MSG_COLS (MSG_COLS),
      .COL_AW   (COL_AW),
      .DIV_WIDTH(DIV_WIDTH)
   ) dut (
      .sys_clk    (sys_clk),
      .rst        (rst),
      .enable     (enable),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .msg_len    (msg_len),
      .step_div   (step_div),
      .frame_out  (frame_out),
      .frame_valid(frame_valid),
      .wrapped    (wrapped)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic logic [7:0] col_of(input logic [63:0] f, input int k);
      logic [7:0] c;
      for (int r = 0; r < 8; r++) c[r] = f[8*r+k];
      return c;
   endfunction

   // Reference model: offset/length arithmetic and a snapshot of each column
   // taken on the clock edge that reads it.
   typedef enum int {M_IDLE, M_STEP, M_WAIT} mmode_t;
   mmode_t      m_mode  = M_IDLE;
   int          m_off   = 0;
   int          m_len   = 0;
   int          m_t     = 0;
   int          m_pre   = 0;
   logic [7:0]  m_mem  [MSG_COLS];
   logic [7:0]  m_snap [8];
   logic [63:0] m_frame = '0;
   logic        m_valid = 1'b0;
   logic        m_wrap  = 1'b0;

   task model_start();
      m_len = (int'(msg_len) > MSG_COLS) ? MSG_COLS : int'(msg_len);
      if (m_off >= m_len) m_off = 0;
      m_t    = (m_len == 0) ? 8 : 0;
      m_mode = M_STEP;
   endtask

   initial begin
      for (int i = 0; i < MSG_COLS; i++) m_mem[i] = '0;
      forever begin
         @(posedge sys_clk or posedge rst);
         if (rst) begin
            m_mode  = M_IDLE;
            m_off   = 0;
            m_pre   = 0;
            m_frame = '0;
            m_valid = 1'b0;
            m_wrap  = 1'b0;
         end else begin
            m_valid = 1'b0;
            m_wrap  = 1'b0;
            case (m_mode)
               M_IDLE: if (enable) model_start();
               M_STEP: begin
                  if (m_t < 8) begin
                     m_snap[m_t] = m_mem[(m_off + m_t) % m_len];
                     m_t++;
                  end else if (m_t == 8) begin
                     m_frame = '0;
                     if (m_len != 0)
                        for (int k = 0; k < 8; k++)
                           for (int r = 0; r < 8; r++) m_frame[8*r+k] = m_snap[k][r];
                     m_valid = 1'b1;
                     m_wrap  = (m_len != 0) && (m_off == m_len - 1);
                     m_t     = 9;
                  end else begin
                     m_off  = (m_len == 0) ? 0 : (m_off + 1) % m_len;
                     m_pre  = int'(step_div);
                     m_mode = M_WAIT;
                  end
               end
               M_WAIT: begin
                  if (!enable)         m_mode = M_IDLE;
                  else if (m_pre == 0) model_start();
                  else                 m_pre--;
               end
               default: m_mode = M_IDLE;
            endcase
            if (wr_en) m_mem[wr_addr] = wr_data;
         end
      end
   end

   initial begin
      @(negedge sys_clk);
      forever begin
         @(negedge sys_clk);
         check("frame_valid", frame_valid, m_valid);
         check("wrapped", wrapped, m_wrap);
         check("frame_out", frame_out, m_frame);
      end
   end

   // Helpers assume they are entered just after a falling edge.
   task automatic wait_valid(output logic [63:0] f, output logic w, output int n);
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (!frame_valid && n < 200);
      check("valid_timeout", frame_valid, 1'b1);
      f = frame_out;
      w = wrapped;
   endtask

   task automatic write_col(input int a, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_addr = COL_AW'(a);
      wr_data = d;
      @(negedge sys_clk);
      wr_en   = 1'b0;
   endtask

   task automatic do_reset();
      enable = 1'b0;
      rst    = 1'b1;
      @(negedge sys_clk);
      rst    = 1'b0;
   endtask

   initial begin
      logic [63:0] f;
      logic        w;
      int          n;
      int          wraps;

      repeat (2) @(negedge sys_clk);
      check("reset_frame", frame_out, 64'h0);
      check("reset_valid", frame_valid, 1'b0);
      check("reset_wrapped", wrapped, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < MSG_COLS; i++) write_col(i, 8'(i + 1));
      msg_len  = 6'd32;
      step_div = 24'd3;

      // First frame latency, step period, two consecutive windows.
      enable = 1'b1;
      wait_valid(f, w, n);
      check("first_latency", n, 10);
      check("first_frame", f, 64'h0000_0000_8078_6655);
      check("first_row0", f[7:0], 8'h55);
      check("first_wrap", w, 1'b0);
      wait_valid(f, w, n);
      check("step_period", n, 14);
      check("second_frame", f, 64'h0000_0000_C03C_33AA);

      // Asynchronous reset in the middle of a fetch.
      repeat (8) @(negedge sys_clk);
      #1 rst = 1'b1;
      #1;
      check("async_rst_frame", frame_out, 64'h0);
      check("async_rst_valid", frame_valid, 1'b0);
      check("async_rst_wrapped", wrapped, 1'b0);
      @(negedge sys_clk);
      rst = 1'b0;
      wait_valid(f, w, n);
      check("post_rst_latency", n, 10);
      check("ram_retained", f, 64'h0000_0000_8078_6655);

      // Enable dropped during DRAIN: commit completes, frame holds, resume at offset 1.
      do_reset();
      enable = 1'b1;
      repeat (9) @(negedge sys_clk);
      enable = 1'b0;
      wait_valid(f, w, n);
      check("drain_drop_latency", n, 1);
      check("drain_drop_frame", f, 64'h0000_0000_8078_6655);
      repeat (20) @(negedge sys_clk);
      check("held_frame", frame_out, 64'h0000_0000_8078_6655);
      enable = 1'b1;
      wait_valid(f, w, n);
      check("resume_latency", n, 10);
      check("resume_offset1", f, 64'h0000_0000_C03C_33AA);

      // Ten-column message: wrap after offset 9, wrapped window at offset 6.
      do_reset();
      msg_len = 6'd10;
      enable  = 1'b1;
      wraps   = 0;
      for (int i = 0; i <= 10; i++) begin
         wait_valid(f, w, n);
         if (w) wraps++;
         if (i == 6) check("len10_offset6", f, 64'h0000_0000_0E81_6955);
         if (i == 9) check("len10_wrap_at_9", w, 1'b1);
      end
      check("len10_wrap_count", wraps, 1);

      // Write to column 5 on the same edge that reads it: old byte now, new byte next.
      do_reset();
      msg_len = 6'd32;
      enable  = 1'b1;
      repeat (6) @(negedge sys_clk);
      wr_en   = 1'b1;
      wr_addr = 5'd5;
      wr_data = 8'hAA;
      @(negedge sys_clk);
      wr_en   = 1'b0;
      wait_valid(f, w, n);
      check("collide_latency", n, 3);
      check("collide_old", col_of(f, 5), 8'h06);
      wait_valid(f, w, n);
      check("collide_new", col_of(f, 4), 8'hAA);

      // Three-column message repeats across the 8-wide window.
      do_reset();
      msg_len = 6'd3;
      write_col(0, 8'hFF);
      write_col(1, 8'h00);
      write_col(2, 8'h00);
      enable = 1'b1;
      wraps  = 0;
      for (int i = 0; i < 6; i++) begin
         wait_valid(f, w, n);
         if (w) wraps++;
         if (i == 0) check("len3_offset0", f, 64'h4949_4949_4949_4949);
         if (i == 1) check("len3_offset1", f, 64'h2424_2424_2424_2424);
         if (i == 2) check("len3_offset2", f, 64'h9292_9292_9292_9292);
      end
      check("len3_wrap_count", wraps, 2);

      // Empty message: blank frames still pulse valid, never wrap.
      msg_len = 6'd0;
      for (int i = 0; i < 3; i++) begin
         wait_valid(f, w, n);
         check("len0_period", n, 6);
         check("len0_frame", f, 64'h0);
         check("len0_wrap", w, 1'b0);
      end

      enable = 1'b0;
      repeat (4) @(negedge sys_clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
